// File: rtl/shifter_pkg.sv
// Shared definitions for the pipelined shifter: op encodings and the
// mapping of shift-network levels onto pipeline stages.
package shifter_pkg;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    function automatic int level_to_stage(input int level, input int stages, input int levels);
        return (level * stages) / levels;
    endfunction

    // Right-going ops run through the left-shift network on a bit-reversed word.
    function automatic logic is_right_op(input logic [1:0] op);
        return op != OP_SLL;
    endfunction

endpackage

// File: rtl/shift_level.sv
// One combinational level of the shift network: left shift by DIST with
// either a constant fill bit or wrap-around of the bits shifted out.
module shift_level #(
    parameter int WIDTH = 32,
    parameter int DIST  = 1
) (
    input  logic [WIDTH-1:0] data_in,
    input  logic             en,
    input  logic             fill,
    input  logic             rotate,
    output logic [WIDTH-1:0] data_out
);

    logic [DIST-1:0] low_bits;

    always_comb begin
        low_bits = rotate ? data_in[WIDTH-1 -: DIST] : {DIST{fill}};
        data_out = en ? {data_in[WIDTH-1-DIST:0], low_bits} : data_in;
    end

endmodule

// File: rtl/pipelined_shifter.sv
// Pipelined SLL/SRL/SRA/ROR shifter with a valid/ready handshake and a
// passthrough tag; a single global advance signal stalls every stage.
module pipelined_shifter
    import shifter_pkg::*;
#(
    parameter  int WIDTH   = 32,
    parameter  int STAGES  = 2,
    parameter  int TAG_W   = 5,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         in_op,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_zero,
    output logic [TAG_W-1:0]   out_tag
);

    function automatic logic [WIDTH-1:0] bit_reverse(input logic [WIDTH-1:0] x);
        logic [WIDTH-1:0] r;
        for (int b = 0; b < WIDTH; b++) begin
            r[b] = x[WIDTH-1-b];
        end
        return r;
    endfunction

    logic               adv;

    logic [STAGES-1:0]  valid_q, valid_d;
    logic [WIDTH-1:0]   data_q  [STAGES];
    logic [WIDTH-1:0]   data_d  [STAGES];
    logic [1:0]         op_q    [STAGES];
    logic [1:0]         op_d    [STAGES];
    logic [SHAMT_W-1:0] shamt_q [STAGES];
    logic [SHAMT_W-1:0] shamt_d [STAGES];
    logic [STAGES-1:0]  fill_q, fill_d;
    logic [TAG_W-1:0]   tag_q   [STAGES];
    logic [TAG_W-1:0]   tag_d   [STAGES];

    // Per-stage source values: stage 0 sees the request, stage s sees bank s-1.
    logic [STAGES-1:0]  src_valid;
    logic [WIDTH-1:0]   src_data  [STAGES];
    logic [1:0]         src_op    [STAGES];
    logic [SHAMT_W-1:0] src_shamt [STAGES];
    logic [STAGES-1:0]  src_fill;
    logic [TAG_W-1:0]   src_tag   [STAGES];

    logic [WIDTH-1:0]   lvl_out [SHAMT_W];
    logic [WIDTH-1:0]   stg_out [STAGES];

    logic               unused_stage_bits;

    always_comb begin
        src_valid[0] = in_valid;
        src_data[0]  = is_right_op(in_op) ? bit_reverse(in_data) : in_data;
        src_op[0]    = in_op;
        src_shamt[0] = in_shamt;
        src_fill[0]  = (in_op == OP_SRA) & in_data[WIDTH-1];
        src_tag[0]   = in_tag;
        for (int s = 1; s < STAGES; s++) begin
            src_valid[s] = valid_q[s-1];
            src_data[s]  = data_q[s-1];
            src_op[s]    = op_q[s-1];
            src_shamt[s] = shamt_q[s-1];
            src_fill[s]  = fill_q[s-1];
            src_tag[s]   = tag_q[s-1];
        end
    end

    for (genvar i = 0; i < SHAMT_W; i++) begin : g_level
        localparam int STG  = level_to_stage(i, STAGES, SHAMT_W);
        localparam bit FIRST = (i == 0) || (level_to_stage(i - 1, STAGES, SHAMT_W) != STG);
        localparam bit LAST  = (i == SHAMT_W - 1) || (level_to_stage(i + 1, STAGES, SHAMT_W) != STG);

        logic [WIDTH-1:0] lvl_in;

        if (FIRST) begin : g_first
            assign lvl_in = src_data[STG];
        end else begin : g_chain
            assign lvl_in = lvl_out[i-1];
        end

        shift_level #(
            .WIDTH (WIDTH),
            .DIST  (2 ** i)
        ) u_level (
            .data_in  (lvl_in),
            .en       (src_shamt[STG][i]),
            .fill     (src_fill[STG]),
            .rotate   (src_op[STG] == OP_ROR),
            .data_out (lvl_out[i])
        );

        if (LAST) begin : g_last
            assign stg_out[STG] = lvl_out[i];
        end
    end

    assign adv = !valid_q[STAGES-1] | out_ready;

    always_comb begin
        for (int s = 0; s < STAGES; s++) begin
            valid_d[s] = adv ? src_valid[s] : valid_q[s];
            data_d[s]  = adv ? stg_out[s]   : data_q[s];
            op_d[s]    = adv ? src_op[s]    : op_q[s];
            shamt_d[s] = adv ? src_shamt[s] : shamt_q[s];
            fill_d[s]  = adv ? src_fill[s]  : fill_q[s];
            tag_d[s]   = adv ? src_tag[s]   : tag_q[s];
        end
        // The last bank stores the result already mapped back to normal bit order.
        if (adv && is_right_op(src_op[STAGES-1])) begin
            data_d[STAGES-1] = bit_reverse(stg_out[STAGES-1]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            fill_q  <= '0;
            for (int s = 0; s < STAGES; s++) begin
                data_q[s]  <= '0;
                op_q[s]    <= '0;
                shamt_q[s] <= '0;
                tag_q[s]   <= '0;
            end
        end else begin
            valid_q <= valid_d;
            fill_q  <= fill_d;
            for (int s = 0; s < STAGES; s++) begin
                data_q[s]  <= data_d[s];
                op_q[s]    <= op_d[s];
                shamt_q[s] <= shamt_d[s];
                tag_q[s]   <= tag_d[s];
            end
        end
    end

    // Shamt bits of levels already applied, and the last stage's control, are never read.
    always_comb begin
        unused_stage_bits = (^fill_q) ^ (^op_q[STAGES-1]);
        for (int s = 0; s < STAGES; s++) begin
            unused_stage_bits = unused_stage_bits ^ (^shamt_q[s]);
        end
    end

    assign in_ready  = adv;
    assign out_valid = valid_q[STAGES-1];
    assign out_data  = data_q[STAGES-1];
    assign out_tag   = tag_q[STAGES-1];
    assign out_zero  = (out_data == '0);

endmodule

// File: tb/tb_pipelined_shifter.sv
// Self-checking bench for pipelined_shifter (WIDTH=32, STAGES=2, TAG_W=5):
// directed vectors plus a randomized scoreboard against an arithmetic model.
module tb_pipelined_shifter;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [31:0] in_data;
    logic [4:0]  in_shamt;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_zero;
    logic [4:0]  out_tag;

    int checks;
    int errors;
    logic [36:0] exp_q[$];

    pipelined_shifter #(.WIDTH(32), .STAGES(2), .TAG_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_zero  (out_zero),
        .out_tag   (out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] d, input int sh);
        logic [63:0] wide;
        case (op)
            2'd0: return d << sh;
            2'd1: return d >> sh;
            2'd2: return 32'($signed(d) >>> sh);
            default: begin
                wide = {d, d} >> sh;
                return wide[31:0];
            end
        endcase
    endfunction

    task automatic drive(input logic [1:0] op, input logic [31:0] d, input logic [4:0] sh, input logic [4:0] tag);
        in_valid = 1'b1;
        in_op    = op;
        in_data  = d;
        in_shamt = sh;
        in_tag   = tag;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        in_valid = 1'b0; in_op = 2'd0; in_data = '0; in_shamt = '0; in_tag = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #4 rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got %h want 0", out_data); end
        checks++; if (out_zero !== 1'b1) begin errors++; $display("FAIL reset_out_zero got %0b want 1", out_zero); end
        checks++; if (out_tag !== 5'd0) begin errors++; $display("FAIL reset_out_tag got %0d want 0", out_tag); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
    endtask

    task automatic test_directed;
        logic [1:0]  t_op  [12];
        logic [31:0] t_dat [12];
        logic [4:0]  t_sh  [12];
        logic [31:0] t_exp [12];
        t_op[0]  = 2'd1; t_dat[0]  = 32'h80000000; t_sh[0]  = 5'd31; t_exp[0]  = 32'h00000001;
        t_op[1]  = 2'd2; t_dat[1]  = 32'hF0000000; t_sh[1]  = 5'd4;  t_exp[1]  = 32'hFF000000;
        t_op[2]  = 2'd2; t_dat[2]  = 32'h70000000; t_sh[2]  = 5'd4;  t_exp[2]  = 32'h07000000;
        t_op[3]  = 2'd3; t_dat[3]  = 32'h00000001; t_sh[3]  = 5'd1;  t_exp[3]  = 32'h80000000;
        t_op[4]  = 2'd0; t_dat[4]  = 32'h00000001; t_sh[4]  = 5'd31; t_exp[4]  = 32'h80000000;
        t_op[5]  = 2'd1; t_dat[5]  = 32'h00000001; t_sh[5]  = 5'd1;  t_exp[5]  = 32'h00000000;
        t_op[6]  = 2'd0; t_dat[6]  = 32'hA5C3_0F96; t_sh[6]  = 5'd0;  t_exp[6]  = 32'hA5C3_0F96;
        t_op[7]  = 2'd1; t_dat[7]  = 32'hA5C3_0F96; t_sh[7]  = 5'd0;  t_exp[7]  = 32'hA5C3_0F96;
        t_op[8]  = 2'd2; t_dat[8]  = 32'hA5C3_0F96; t_sh[8]  = 5'd0;  t_exp[8]  = 32'hA5C3_0F96;
        t_op[9]  = 2'd3; t_dat[9]  = 32'hA5C3_0F96; t_sh[9]  = 5'd0;  t_exp[9]  = 32'hA5C3_0F96;
        t_op[10] = 2'd2; t_dat[10] = 32'h80000000; t_sh[10] = 5'd31; t_exp[10] = 32'hFFFFFFFF;
        t_op[11] = 2'd3; t_dat[11] = 32'h00000003; t_sh[11] = 5'd31; t_exp[11] = 32'h00000006;
        out_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            drive(t_op[k], t_dat[k], t_sh[k], 5'(k + 3));
            @(posedge clk); #1;
            in_valid = 1'b0;
            checks++;
            if (out_valid !== 1'b0) begin
                errors++; $display("FAIL dir%0d_early_valid got %0b want 0", k, out_valid);
            end
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || out_data !== t_exp[k] || out_tag !== 5'(k + 3)
                || out_zero !== (t_exp[k] == 32'h0)) begin
                errors++;
                $display("FAIL dir%0d_result got v=%0b d=%h t=%0d z=%0b want v=1 d=%h t=%0d z=%0b",
                         k, out_valid, out_data, out_tag, out_zero, t_exp[k], k + 3, t_exp[k] == 32'h0);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back;
        logic [1:0]  b_op  [4];
        logic [31:0] b_dat [4];
        logic [4:0]  b_sh  [4];
        for (int i = 0; i < 4; i++) begin
            b_op[i] = 2'($urandom_range(0, 3)); b_dat[i] = $urandom; b_sh[i] = 5'($urandom_range(0, 31));
        end
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 5; cyc++) begin
            if (cyc < 4) drive(b_op[cyc], b_dat[cyc], b_sh[cyc], 5'(cyc));
            else in_valid = 1'b0;
            @(posedge clk); #1;
            if (cyc >= 1) begin
                checks++;
                if (out_valid !== 1'b1 || out_tag !== 5'(cyc - 1)
                    || out_data !== ref_shift(b_op[cyc-1], b_dat[cyc-1], int'(b_sh[cyc-1]))) begin
                    errors++;
                    $display("FAIL b2b%0d got v=%0b t=%0d d=%h want v=1 t=%0d d=%h", cyc - 1, out_valid,
                             out_tag, out_data, cyc - 1, ref_shift(b_op[cyc-1], b_dat[cyc-1], int'(b_sh[cyc-1])));
                end
            end
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_tail_valid got %0b want 0", out_valid); end
    endtask

    task automatic test_backpressure;
        logic [31:0] e [3];
        logic [31:0] d [3];
        for (int i = 0; i < 3; i++) begin
            d[i] = $urandom;
            e[i] = ref_shift(2'd2, d[i], 7);
        end
        out_ready = 1'b0;
        drive(2'd2, d[0], 5'd7, 5'd10);
        @(posedge clk); #1;
        drive(2'd2, d[1], 5'd7, 5'd11);
        @(posedge clk); #1;
        drive(2'd2, d[2], 5'd7, 5'd12);
        for (int h = 0; h < 3; h++) begin
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== e[0] || out_tag !== 5'd10) begin
                errors++;
                $display("FAIL bp_hold%0d got rdy=%0b v=%0b d=%h t=%0d want rdy=0 v=1 d=%h t=10",
                         h, in_ready, out_valid, out_data, out_tag, e[0]);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_data !== e[0] || out_tag !== 5'd10) begin
            errors++; $display("FAIL bp_release got rdy=%0b d=%h t=%0d want rdy=1 d=%h t=10", in_ready, out_data, out_tag, e[0]);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int k = 1; k < 3; k++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== e[k] || out_tag !== 5'(10 + k)) begin
                errors++;
                $display("FAIL bp_drain%0d got v=%0b d=%h t=%0d want v=1 d=%h t=%0d", k, out_valid, out_data, out_tag, e[k], 10 + k);
            end
            @(posedge clk); #1;
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got v=%0b want 0", out_valid); end
    endtask

    task automatic test_random;
        logic        hold_v;
        logic [31:0] hold_d;
        logic [4:0]  hold_t;
        logic [36:0] e;
        hold_v = 1'b0; hold_d = '0; hold_t = '0;
        exp_q.delete();
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (cyc < 360) begin
                in_valid  = ($urandom_range(0, 3) != 0);
                in_op     = 2'($urandom_range(0, 3));
                in_data   = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
                in_shamt  = ($urandom_range(0, 3) == 0) ? 5'(31 * $urandom_range(0, 1)) : 5'($urandom_range(0, 31));
                in_tag    = 5'($urandom_range(0, 31));
                out_ready = ($urandom_range(0, 9) < 7);
            end else begin
                in_valid  = 1'b0;
                out_ready = 1'b1;
            end
            @(negedge clk);
            if (hold_v) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== hold_d || out_tag !== hold_t) begin
                    errors++;
                    $display("FAIL rnd_stall c%0d got v=%0b d=%h t=%0d want v=1 d=%h t=%0d", cyc, out_valid, out_data, out_tag, hold_d, hold_t);
                end
            end
            checks++;
            if (in_ready !== (!out_valid || out_ready)) begin
                errors++; $display("FAIL rnd_ready c%0d got %0b want %0b", cyc, in_ready, !out_valid || out_ready);
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL rnd_extra c%0d got t=%0d d=%h want none", cyc, out_tag, out_data);
                end else begin
                    e = exp_q.pop_front();
                    if (out_tag !== e[36:32] || out_data !== e[31:0] || out_zero !== (e[31:0] == 32'h0)) begin
                        errors++;
                        $display("FAIL rnd_result c%0d got t=%0d d=%h z=%0b want t=%0d d=%h z=%0b",
                                 cyc, out_tag, out_data, out_zero, e[36:32], e[31:0], e[31:0] == 32'h0);
                    end
                end
            end
            if (in_valid && in_ready) exp_q.push_back({in_tag, ref_shift(in_op, in_data, int'(in_shamt))});
            hold_v = out_valid && !out_ready;
            hold_d = out_data;
            hold_t = out_tag;
            @(posedge clk); #1;
        end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL rnd_lost got %0d pending want 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] d;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(2'($urandom_range(0, 3)), $urandom | 32'h1, 5'd0, 5'(20 + i));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || out_zero !== 1'b1 || out_tag !== 5'd0) begin
            errors++;
            $display("FAIL mid_reset got v=%0b d=%h z=%0b t=%0d want v=0 d=0 z=1 t=0", out_valid, out_data, out_zero, out_tag);
        end
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_stale got v=%0b want 0", out_valid); end
        d = $urandom;
        drive(2'd1, d, 5'd3, 5'd9);
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_early got v=%0b want 0", out_valid); end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b1 || out_data !== (d >> 3) || out_tag !== 5'd9) begin
            errors++;
            $display("FAIL mid_first got v=%0b d=%h t=%0d want v=1 d=%h t=9", out_valid, out_data, out_tag, d >> 3);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/pipelined_shifter.md
Name: pipelined_shifter

Overview:
- Parametrised, pipelined successor to the team's 32-bit combinational right shifter, used in the ALU execute path.
- Supports four shift modes: logical left, logical right, arithmetic right and rotate right.
- Operand width and pipeline depth are configurable.
- Carries a valid/ready handshake with a sideband tag so results stay matched to their issuing instruction under stalls.

Parameters:
- WIDTH, 32, operand width; power of two, 8..64.
- STAGES, 2, register stages between accept and result; 1..$clog2(WIDTH).
- TAG_W, 5, width of the passthrough tag (destination register id).
- SHAMT_W, $clog2(WIDTH), derived localparam; not overridable.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  reset: asynchronous, active-low.
- in_valid  in  1  request present.
- in_ready  out  1  block accepts a request this cycle.
- in_op  in  2  mode: 00 SLL, 01 SRL, 10 SRA, 11 ROR.
- in_data  in  WIDTH  operand.
- in_shamt  in  SHAMT_W  shift amount.
- in_tag  in  TAG_W  sideband tag, returned unchanged.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- out_data  out  WIDTH  shifted result.
- out_zero  out  1  out_data == 0.
- out_tag  out  TAG_W  tag of the result.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset:
  - All stage valid bits clear; out_valid=0.
  - out_data=0, out_zero=1, out_tag=0.
  - in_ready is 1 immediately after reset deasserts.
- Accept and release:
  - A request is accepted when in_valid & in_ready at a rising edge.
  - A result is released when out_valid & out_ready.
- Global stall:
  - adv = !out_valid | out_ready; in_ready = adv.
  - When adv=0, every stage register, including data, op and tag, holds.
  - Bubbles are not compressed.
- Latency and throughput:
  - Latency is exactly STAGES cycles from accept to out_valid with no stall.
  - Throughput is one result per cycle while out_ready=1.
- Shift network:
  - SHAMT_W levels; level i shifts by 2^i when shamt[i]=1.
  - Level i is evaluated in stage floor(i*STAGES/SHAMT_W). The last stage's register drives the outputs.
  - Op, remaining shamt bits, tag and valid travel with the data.
- Right modes:
  - Operand is bit-reversed at input, left-shifted, and bit-reversed at output.
  - Fill bit: 0 for SLL/SRL; original in_data[WIDTH-1] for SRA (carried as a stage bit).
  - ROR uses a wrapped left rotate of the reversed word: bits shifted out re-enter.
- Boundaries:
  - shamt=0 returns in_data unchanged for all ops.
  - shamt=WIDTH-1 is the maximum; there is no modulo beyond SHAMT_W bits.
  - SRA of a negative operand fills with ones.
- in_valid=0 with adv=1 inserts a bubble; stage valid clears and data is don't-care.
- out_zero is computed combinationally from out_data (not registered separately).
- Simultaneous accept and release with the pipeline full is legal; the pipeline advances fully.
- Reset mid-operation discards all in-flight requests. No output valid until new accepts.

Decomposition:
- Shared package shifter_pkg:
  - op encodings OP_SLL=2'b00, OP_SRL=2'b01, OP_SRA=2'b10, OP_ROR=2'b11.
  - A function mapping level index to stage index.
- One sub-module, shift_level: a combinational single level with parameters WIDTH and DIST (2^i), inputs data, en, fill, rotate, output data.
- pipelined_shifter generates SHAMT_W shift_level instances and STAGES register banks.

Test Plan (WIDTH=32, STAGES=2, TAG_W=5):
- SRL, data 0x80000000, shamt 31, tag 3 → two cycles later out_data 0x00000001, out_tag 3, out_zero 0.
- SRA, data 0xF0000000, shamt 4 → 0xFF000000. SRA, data 0x70000000, shamt 4 → 0x07000000.
- ROR, data 0x00000001, shamt 1 → 0x80000000. SLL, data 0x00000001, shamt 31 → 0x80000000. SRL, data 0x1, shamt 1 → 0, out_zero 1.
- Back-to-back ops on 4 consecutive cycles, out_ready=1 → 4 results on 4 consecutive cycles, in order, tags 0..3.
- Backpressure: hold out_ready=0 for 3 cycles with pipeline full → in_ready=0, out_data/out_tag stable. Release → ordered drain, nothing lost or duplicated.
- Assert rst_n=0 mid-stream, asynchronously between edges → out_valid drops immediately, out_data=0. After release, the first new request appears after exactly 2 cycles.
